gray_rx_check: RTL and testbench

GRAY_RX_CHECK -- requirements
Module: gray_rx_check

---
 rtl/gray_rx_if.sv | 22 ++
 rtl/gray_rx_check.sv | 119 +++++++++++
 tb/tb_gray_rx_check.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/gray_rx_if.sv
// Gray-count receive bundle: gray sample in, decoded count and status out.
interface gray_rx_if #(
    parameter int W = 4
);
    logic [W-1:0] gray_in;
    logic         clr_err;
    logic [W-1:0] bin_out;
    logic         bin_vld;
    logic         step_err;
    logic [7:0]   err_cnt;
    logic         locked;

    modport master (
        output gray_in, clr_err,
        input  bin_out, bin_vld, step_err, err_cnt, locked
    );

    modport slave (
        input  gray_in, clr_err,
        output bin_out, bin_vld, step_err, err_cnt, locked
    );
endinterface

// File: rtl/gray_rx_check.sv
// Synchronizes a foreign gray count, decodes it to binary and polices steps.
// Locks after LOCK_N quiet/single-step samples; drops lock on jumps.
module gray_rx_check #(
    parameter int W      = 4,
    parameter int LOCK_N = 4
) (
    input logic       clk,
    input logic       reset,
    gray_rx_if.slave  rx
);
    typedef enum logic {UNLOCKED, TRACK} state_t;

    localparam int CW = (LOCK_N > 1) ? $clog2(LOCK_N) : 1;
    localparam logic [CW-1:0] LAST = CW'(LOCK_N - 1);

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    state_t        state, state_n;
    logic [W-1:0]  s1, s2;
    logic [W-1:0]  prev_g, prev_n;
    logic [W-1:0]  bin_q, bin_n;
    logic [CW-1:0] lock_cnt, lock_n;
    logic [7:0]    err_q, err_cnt_n;
    logic          vld_q, vld_n;
    logic          serr_q, serr_n;

    logic [W-1:0]  diff, b_s2, b_prev;
    logic          d_zero, d_le1, fwd, bwd;

    assign diff   = s2 ^ prev_g;
    assign d_zero = (diff == '0);
    assign d_le1  = ((diff & (diff - W'(1))) == '0);
    assign b_s2   = g2b(s2);
    assign b_prev = g2b(prev_g);
    assign fwd    = (b_s2 == b_prev + W'(1));
    assign bwd    = (b_s2 == b_prev - W'(1));

    always_comb begin
        state_n = state;
        prev_n  = prev_g;
        bin_n   = bin_q;
        lock_n  = lock_cnt;
        vld_n   = 1'b0;
        serr_n  = 1'b0;
        unique case (state)
            UNLOCKED: begin
                prev_n = s2;
                if (!d_le1) begin
                    lock_n = '0;
                end else if (lock_cnt == LAST) begin
                    state_n = TRACK;
                    bin_n   = b_s2;
                    lock_n  = '0;
                end else begin
                    lock_n = lock_cnt + 1'b1;
                end
            end
            TRACK: begin
                if (!d_zero) begin
                    prev_n = s2;
                    // one-bit changes that are not +/-1 are jumps too
                    if (d_le1 && (fwd || bwd)) begin
                        bin_n  = b_s2;
                        vld_n  = 1'b1;
                        serr_n = !fwd;
                    end else begin
                        serr_n  = 1'b1;
                        lock_n  = '0;
                        state_n = UNLOCKED;
                    end
                end
            end
            default: state_n = UNLOCKED;
        endcase
    end

    always_comb begin
        err_cnt_n = err_q;
        if (rx.clr_err)
            err_cnt_n = '0;
        else if (serr_n && err_q != 8'hFF)
            err_cnt_n = err_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1       <= '0;
            s2       <= '0;
            state    <= UNLOCKED;
            prev_g   <= '0;
            bin_q    <= '0;
            lock_cnt <= '0;
            err_q    <= '0;
            vld_q    <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            s1       <= rx.gray_in;
            s2       <= s1;
            state    <= state_n;
            prev_g   <= prev_n;
            bin_q    <= bin_n;
            lock_cnt <= lock_n;
            err_q    <= err_cnt_n;
            vld_q    <= vld_n;
            serr_q   <= serr_n;
        end
    end

    assign rx.bin_out  = bin_q;
    assign rx.bin_vld  = vld_q;
    assign rx.step_err = serr_q;
    assign rx.err_cnt  = err_q;
    assign rx.locked   = (state == TRACK);
endmodule

// File: tb/tb_gray_rx_check.sv
// Bench for gray_rx_check: directed gray steps, scoreboard on output pulses.
module tb_gray_rx_check;
    logic clk;
    logic reset;

    gray_rx_if #(.W(4)) rx ();

    gray_rx_check #(.W(4), .LOCK_N(4)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic       err;
        logic [3:0] bin;
    } ev_t;

    ev_t q[$];
    int  checks   = 0;
    int  failures = 0;
    int  exp_err  = 0;
    int  cur      = 0;

    logic [3:0] gt [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic v, input logic e, input logic [3:0] b);
        ev_t x;
        x.vld = v;
        x.err = e;
        x.bin = b;
        q.push_back(x);
    endtask

    task automatic mv(input logic [3:0] g, input logic v, input logic e,
                      input logic [3:0] b, input int hold);
        rx.gray_in = g;
        if (v || e) push(v, e, b);
        if (e) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        repeat (hold) tick();
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (reset && (rx.bin_vld || rx.step_err)) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse actual vld=%0b err=%0b bin=%0d required none",
                         rx.bin_vld, rx.step_err, rx.bin_out);
            end else begin
                ev_t x;
                x = q.pop_front();
                if (rx.bin_vld !== x.vld || rx.step_err !== x.err ||
                    rx.bin_out !== x.bin) begin
                    failures++;
                    $display("FAIL event actual vld=%0b err=%0b bin=%0d required vld=%0b err=%0b bin=%0d",
                             rx.bin_vld, rx.step_err, rx.bin_out, x.vld, x.err, x.bin);
                end
            end
        end
    end

    initial begin
        reset      = 1'b0;
        rx.gray_in = 4'h0;
        rx.clr_err = 1'b0;
        #3;
        chk("rst_bin", rx.bin_out, 0);
        chk("rst_vld", rx.bin_vld, 0);
        chk("rst_serr", rx.step_err, 0);
        chk("rst_errcnt", rx.err_cnt, 0);
        chk("rst_locked", rx.locked, 0);
        tick();
        tick();
        reset = 1'b1;

        repeat (3) tick();
        chk("lock_early", rx.locked, 0);
        tick();
        chk("lock_4", rx.locked, 1);
        chk("lock_bin", rx.bin_out, 0);
        chk("lock_errcnt", rx.err_cnt, 0);

        // first step with explicit latency checks
        rx.gray_in = gt[1];
        push(1'b1, 1'b0, 4'd1);
        tick();
        tick();
        chk("lat_vld_early", rx.bin_vld, 0);
        chk("lat_bin_early", rx.bin_out, 0);
        tick();
        chk("lat_vld", rx.bin_vld, 1);
        chk("lat_bin", rx.bin_out, 1);

        for (int b = 2; b < 16; b++) mv(gt[b], 1'b1, 1'b0, 4'(b), 3);
        chk("fwd_bin15", rx.bin_out, 15);
        chk("fwd_errcnt", rx.err_cnt, 0);

        mv(4'h0, 1'b1, 1'b0, 4'd0, 3);
        chk("wrap_bin", rx.bin_out, 0);
        chk("wrap_serr", rx.step_err, 0);
        chk("wrap_locked", rx.locked, 1);

        mv(gt[1], 1'b1, 1'b0, 4'd1, 3);
        mv(4'h6, 1'b0, 1'b1, 4'd1, 3);
        chk("jump_serr", rx.step_err, 1);
        chk("jump_locked", rx.locked, 0);
        chk("jump_errcnt", rx.err_cnt, 1);
        chk("jump_bin", rx.bin_out, 1);
        repeat (3) tick();
        chk("relock_early", rx.locked, 0);
        tick();
        chk("relock", rx.locked, 1);
        chk("relock_bin", rx.bin_out, 4);

        mv(gt[3], 1'b1, 1'b1, 4'd3, 3);
        mv(gt[2], 1'b1, 1'b1, 4'd2, 3);
        mv(gt[1], 1'b1, 1'b1, 4'd1, 3);
        chk("back_bin", rx.bin_out, 1);
        chk("back_vld", rx.bin_vld, 1);
        chk("back_serr", rx.step_err, 1);
        chk("back_errcnt", rx.err_cnt, 4);
        chk("back_locked", rx.locked, 1);

        cur = 1;
        for (int i = 0; i < 260; i++) begin
            cur = (cur + 15) % 16;
            mv(gt[cur], 1'b1, 1'b1, 4'(cur), 1);
        end
        repeat (3) tick();
        chk("sat_errcnt", rx.err_cnt, 255);
        chk("sat_exp", exp_err, 255);
        repeat (3) tick();
        chk("sat_hold", rx.err_cnt, 255);
        chk("sat_locked", rx.locked, 1);

        cur = (cur + 15) % 16;
        rx.gray_in = gt[cur];
        push(1'b1, 1'b1, 4'(cur));
        tick();
        tick();
        rx.clr_err = 1'b1;
        tick();
        rx.clr_err = 1'b0;
        chk("clr_serr", rx.step_err, 1);
        chk("clr_errcnt", rx.err_cnt, 0);

        cur = (cur + 15) % 16;
        mv(gt[cur], 1'b1, 1'b1, 4'(cur), 3);
        chk("post_clr_errcnt", rx.err_cnt, 1);

        cur = (cur + 15) % 16;
        rx.gray_in = gt[cur];
        tick();
        #3;
        reset = 1'b0;
        #1;
        chk("arst_bin", rx.bin_out, 0);
        chk("arst_vld", rx.bin_vld, 0);
        chk("arst_serr", rx.step_err, 0);
        chk("arst_errcnt", rx.err_cnt, 0);
        chk("arst_locked", rx.locked, 0);
        q.delete();
        rx.gray_in = 4'h0;
        tick();
        reset = 1'b1;
        repeat (3) tick();
        chk("reacq_early", rx.locked, 0);
        tick();
        chk("reacq", rx.locked, 1);
        chk("reacq_bin", rx.bin_out, 0);

        repeat (3) tick();
        chk("sb_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
